// File: rtl/mipi_tx_packet_engine.sv
// CSI-2 packet serializer: turns one timing-generator command into a header,
// optional payload with CRC-16, and an inter-packet gap on a byte-wide lane.
module mipi_tx_packet_engine #(
   parameter logic [1:0] VC         = 2'd0,
   parameter logic [7:0] GAP_CYCLES = 8'd4
) (
   input  logic        CLK_tx,
   input  logic        RSTn,
   input  logic [5:0]  cmd_data_type,
   input  logic [15:0] cmd_byte_count,
   input  logic        cmd_req,
   output logic        cmd_ack,
   output logic        payload_en,
   output logic        payload_en_last,
   input  logic [7:0]  payload_data,
   output logic [7:0]  hs_data,
   output logic        hs_valid,
   output logic        hs_sop,
   output logic        hs_eop,
   output logic        busy
);

   typedef enum logic [2:0] {IDLE, HDR, PAY, CRC, GAP} state_t;

   localparam logic [23:0] ECC_M0 = 24'hF12CB7;
   localparam logic [23:0] ECC_M1 = 24'hF2555B;
   localparam logic [23:0] ECC_M2 = 24'h749A6D;
   localparam logic [23:0] ECC_M3 = 24'hB8E38E;
   localparam logic [23:0] ECC_M4 = 24'hDF03F0;
   localparam logic [23:0] ECC_M5 = 24'hEFFC00;

   state_t      state;
   logic [5:0]  dt_q;
   logic [15:0] wc_q;
   logic [1:0]  bidx;
   logic [15:0] pcnt;
   logic [7:0]  gcnt;
   logic [15:0] crc;

   logic        is_long;
   logic        has_pay;
   logic [7:0]  di;
   logic [23:0] hdr_word;
   logic [5:0]  ecc;
   logic [15:0] wc_m1;

   assign is_long  = (dt_q[5:4] != 2'b00);
   assign has_pay  = is_long && (wc_q != 16'd0);
   assign di       = {VC, dt_q};
   assign hdr_word = {wc_q, di};
   assign wc_m1    = wc_q - 16'd1;
   assign ecc      = {^(hdr_word & ECC_M5), ^(hdr_word & ECC_M4), ^(hdr_word & ECC_M3),
                      ^(hdr_word & ECC_M2), ^(hdr_word & ECC_M1), ^(hdr_word & ECC_M0)};

   function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [7:0] d);
      logic [15:0] c;
      c = c_in ^ {8'h00, d};
      for (int unsigned i = 0; i < 8; i++)
         c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
      return c;
   endfunction

   // Lane outputs decode straight from the registered state so payload bytes
   // can pass through in the cycle after their read strobe without a bubble.
   always_comb begin
      cmd_ack         = (state == IDLE) && cmd_req;
      busy            = (state != IDLE);
      payload_en      = 1'b0;
      payload_en_last = 1'b0;
      hs_data         = 8'h00;
      hs_valid        = 1'b0;
      hs_sop          = 1'b0;
      hs_eop          = 1'b0;
      case (state)
         HDR: begin
            hs_valid = 1'b1;
            hs_sop   = (bidx == 2'd0);
            case (bidx)
               2'd0:    hs_data = di;
               2'd1:    hs_data = wc_q[7:0];
               2'd2:    hs_data = wc_q[15:8];
               default: hs_data = {2'b00, ecc};
            endcase
            hs_eop          = (bidx == 2'd3) && !is_long;
            payload_en      = (bidx == 2'd3) && has_pay;
            payload_en_last = (bidx == 2'd3) && has_pay && (wc_q == 16'd1);
         end
         PAY: begin
            hs_valid        = 1'b1;
            hs_data         = payload_data;
            payload_en      = (pcnt != wc_m1);
            payload_en_last = ((pcnt + 16'd1) == wc_m1);
         end
         CRC: begin
            hs_valid = 1'b1;
            hs_data  = bidx[0] ? crc[15:8] : crc[7:0];
            hs_eop   = bidx[0];
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK_tx or negedge RSTn) begin
      if (!RSTn) begin
         state <= IDLE;
         dt_q  <= '0;
         wc_q  <= '0;
         bidx  <= '0;
         pcnt  <= '0;
         gcnt  <= '0;
         crc   <= '1;
      end else begin
         case (state)
            IDLE: if (cmd_req) begin
               dt_q  <= cmd_data_type;
               wc_q  <= cmd_byte_count;
               bidx  <= '0;
               pcnt  <= '0;
               crc   <= '1;
               state <= HDR;
            end
            HDR: begin
               bidx <= bidx + 2'd1;
               if (bidx == 2'd3) begin
                  gcnt <= '0;
                  if (!is_long)
                     state <= (GAP_CYCLES == 8'd0) ? IDLE : GAP;
                  else if (wc_q == 16'd0)
                     state <= CRC;
                  else
                     state <= PAY;
               end
            end
            PAY: begin
               crc  <= crc_step(crc, payload_data);
               pcnt <= pcnt + 16'd1;
               if (pcnt == wc_m1) state <= CRC;
            end
            CRC: begin
               bidx <= bidx + 2'd1;
               if (bidx[0]) begin
                  gcnt  <= '0;
                  state <= (GAP_CYCLES == 8'd0) ? IDLE : GAP;
               end
            end
            GAP: begin
               gcnt <= gcnt + 8'd1;
               if (gcnt == GAP_CYCLES - 8'd1) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
